// File: rtl/psum_accum_buffer.sv
// Partial-sum buffer between the corelet OFIFO and the SFP.
// It runs three kinds of command:
//   WRITE    - stores OFIFO rows into a contiguous address range.
//   ACCUM    - adds OFIFO rows into the stored rows, saturating each lane.
//   READOUT  - streams stored rows to the SFP, with optional ReLU.
// Ports:
//   clk, reset                   clock; synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op/base/len/relu         command fields
//   in_valid/in_data/in_rd       OFIFO row input; in_rd is the pop
//   out_valid/out_data/out_ready row output to the SFP
//   done                         one-cycle pulse when a command completes
//   busy                         high while a command is in progress
module psum_accum_buffer #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 2048,
  parameter int addr_bw = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [addr_bw-1:0]       cmd_base,
  input  logic [addr_bw:0]         cmd_len,
  input  logic                     cmd_relu,
  input  logic                     in_valid,
  input  logic [psum_bw*col-1:0]   in_data,
  output logic                     in_rd,
  output logic                     out_valid,
  output logic [psum_bw*col-1:0]   out_data,
  input  logic                     out_ready,
  output logic                     done,
  output logic                     busy
);

  localparam int unsigned ROW_W = psum_bw * col;
  localparam int unsigned LEN_W = addr_bw + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [psum_bw-1:0] LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  // Per-lane signed add, clamped to the lane range on overflow.
  function automatic logic [ROW_W-1:0] sat_add(input logic [ROW_W-1:0] a,
                                               input logic [ROW_W-1:0] b);
    logic [psum_bw:0]   s;
    logic [ROW_W-1:0]   r;
    r = '0;
    for (int k = 0; k < col; k++) begin
      s = {a[k*psum_bw + psum_bw - 1], a[k*psum_bw +: psum_bw]} +
          {b[k*psum_bw + psum_bw - 1], b[k*psum_bw +: psum_bw]};
      // The two top bits differ only when the sum left the lane range.
      if (s[psum_bw] != s[psum_bw-1]) r[k*psum_bw +: psum_bw] = s[psum_bw] ? LANE_MIN : LANE_MAX;
      else                            r[k*psum_bw +: psum_bw] = s[psum_bw-1:0];
    end
    return r;
  endfunction

  // Negative lanes become zero.
  function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] a);
    logic [ROW_W-1:0] r;
    r = a;
    for (int k = 0; k < col; k++) begin
      if (a[k*psum_bw + psum_bw - 1]) r[k*psum_bw +: psum_bw] = '0;
    end
    return r;
  endfunction

  logic [ROW_W-1:0]   mem_q [depth];

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               relu_q, relu_d;
  logic [addr_bw-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               stg_valid_q, stg_valid_d;
  logic [addr_bw-1:0] stg_addr_q, stg_addr_d;
  logic [ROW_W-1:0]   stg_data_q, stg_data_d;
  logic [ROW_W-1:0]   acc_old_q, acc_old_d;
  logic               out_valid_q, out_valid_d;
  logic [ROW_W-1:0]   out_data_q, out_data_d;
  logic               done_q, done_d;

  logic               mem_we;
  logic [addr_bw-1:0] mem_waddr;
  logic [ROW_W-1:0]   mem_wdata;
  logic [ROW_W-1:0]   rd_row;
  logic               load;

  // Handshake strobes depend only on state and counters.
  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign in_rd     = (state_q == ST_DRAIN) && (rem_q != '0) && !reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

  // Next-state, datapath and memory write-port control.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    relu_d      = relu_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    stg_valid_d = 1'b0;
    stg_addr_d  = stg_addr_q;
    stg_data_d  = stg_data_q;
    acc_old_d   = acc_old_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = addr_q;
    mem_wdata   = in_data;
    rd_row      = mem_q[addr_q];
    load        = 1'b0;

    // ACCUM stage 1 commits the previous cycle's saturated sum.
    if (stg_valid_q) begin
      mem_we    = 1'b1;
      mem_waddr = stg_addr_q;
      mem_wdata = sat_add(acc_old_q, stg_data_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          relu_d = cmd_relu;
          addr_d = cmd_base;
          rem_d  = (cmd_len > LEN_W'(depth)) ? LEN_W'(depth) : cmd_len;
          if ((cmd_len == '0) || (cmd_op == OP_RSVD)) begin
            state_d = ST_FLUSH;
            done_d  = 1'b1;
          end else if (cmd_op == OP_READ) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (rem_q == '0) begin
          state_d = ST_FLUSH;
          done_d  = 1'b1;
        end else if (in_valid && in_rd) begin
          rem_d  = rem_q - LEN_W'(1);
          addr_d = addr_q + addr_bw'(1);
          if (op_q == OP_WRITE) begin
            mem_we    = 1'b1;
            mem_waddr = addr_q;
            mem_wdata = in_data;
          end else begin
            stg_valid_d = 1'b1;
            stg_addr_d  = addr_q;
            stg_data_d  = in_data;
            acc_old_d   = rd_row;
          end
        end
      end

      ST_READ: begin
        load = (!out_valid_q || out_ready) && (rem_q != '0);
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = relu_q ? relu_row(rd_row) : rd_row;
          rem_d       = rem_q - LEN_W'(1);
          addr_d      = addr_q + addr_bw'(1);
        end
        if ((rem_q == '0) && (!out_valid_q || out_ready)) begin
          state_d = ST_FLUSH;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      relu_q      <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      stg_valid_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
      acc_old_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      relu_q      <= relu_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
      acc_old_q   <= acc_old_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  // Row storage. Reset does not clear it, and a write pending during reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Self-checking bench for psum_accum_buffer: scoreboard queues and a behavioural memory model.
module tb_psum_accum_buffer;

  localparam int PBW   = 16;
  localparam int COL   = 8;
  localparam int DEPTH = 2048;
  localparam int ABW   = 11;
  localparam int W     = PBW * COL;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_op = '0;
  logic [ABW-1:0] cmd_base = '0;
  logic [ABW:0]   cmd_len = '0;
  logic           cmd_relu = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_rd;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready = 1'b1;
  logic           done;
  logic           busy;

  psum_accum_buffer #(.psum_bw(PBW), .col(COL), .depth(DEPTH), .addr_bw(ABW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_relu(cmd_relu),
    .in_valid(in_valid), .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;   // number of rising edges seen so far

  always @(posedge clk) cyc++;

  logic [W-1:0] ref_mem [DEPTH];
  logic [W-1:0] exp_rows [$];
  int           exp_done [$];
  logic [W-1:0] src_rows [$];
  bit           rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic check_row(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Reference arithmetic on whole lanes as plain integers.
  function automatic logic [W-1:0] model_accum(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]      r;
    logic signed [15:0] la, lb;
    int                s;
    r = '0;
    for (int k = 0; k < COL; k++) begin
      la = a[k*PBW +: PBW];
      lb = b[k*PBW +: PBW];
      s  = int'(la) + int'(lb);
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      r[k*PBW +: PBW] = 16'(s);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model_relu(input logic [W-1:0] a);
    logic [W-1:0]      r;
    logic signed [15:0] la;
    r = a;
    for (int k = 0; k < COL; k++) begin
      la = a[k*PBW +: PBW];
      if (la < 0) r[k*PBW +: PBW] = '0;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rep(input int v);
    logic [W-1:0] r;
    for (int k = 0; k < COL; k++) r[k*PBW +: PBW] = 16'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] alt(input int ev, input int od);
    logic [W-1:0] r;
    for (int k = 0; k < COL; k++) r[k*PBW +: PBW] = (k % 2 == 0) ? 16'(ev) : 16'(od);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int k = 0; k < COL; k++) r[k*PBW +: PBW] = 16'($urandom);
    return r;
  endfunction

  function automatic int eff_len(input int op, input int len);
    if (op == 3) return 0;
    return (len > DEPTH) ? DEPTH : len;
  endfunction

  // Output monitor: pops the scoreboard on every row transfer and done pulse.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_int("stall_valid_held", 32'(out_valid), 32'd1);
        check_row("stall_data_held", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_rows.size() == 0) fail_now("unexpected_out_row");
        else check_row("out_row", out_data, exp_rows.pop_front());
      end
      if (done) begin
        check_int("cmd_ready_low_during_done", 32'(cmd_ready), 32'd0);
        if (exp_done.size() == 0) fail_now("unexpected_done");
        else check_int("done_cycle", 32'(cyc + 1), 32'(exp_done.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Presents a command until accepted; t_acc is the accepting edge.
  task automatic issue(input int op, input int base, input int len, input bit relu, output int t_acc);
    int b, n;
    bit ok;
    b = 0; ok = 1'b0; t_acc = 0;
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_base = 11'(base); cmd_len = 12'(len); cmd_relu = relu;
    while (!ok && b < 200) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        t_acc = cyc + 1;
        n = eff_len(op, len);
        if (n == 0) exp_done.push_back(t_acc + 1);
        else if (op == 2)
          for (int i = 0; i < n; i++)
            exp_rows.push_back(relu ? model_relu(ref_mem[(base + i) % DEPTH]) : ref_mem[(base + i) % DEPTH]);
      end
      @(posedge clk); #1;
      b++;
    end
    cmd_valid = 1'b0;
    if (!ok) fail_now("cmd_accept_timeout");
  endtask

  // WRITE/ACCUM from src_rows; abort>0 stops after that many rows (left mid-command).
  task automatic drain(input int op, input int base, input int len, input bit gaps, input int abort);
    int t, n, idx, rdc, b, last, a;
    idx = 0; rdc = 0; b = 0; last = 0;
    issue(op, base, len, 1'b0, t);
    n = eff_len(op, len);
    while (idx < n && b < 8 * n + 50) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = src_rows[idx];
      @(negedge clk);
      if (in_rd) rdc++;
      if (in_valid && in_rd) begin
        a = (base + idx) % DEPTH;
        ref_mem[a] = (op == 0) ? src_rows[idx] : model_accum(ref_mem[a], src_rows[idx]);
        idx++;
        last = cyc + 1;
        if (idx == n) exp_done.push_back(last + 2);
      end
      @(posedge clk); #1;
      b++;
      if (abort > 0 && idx == abort) break;
    end
    in_valid = 1'b0;
    if (abort == 0) begin
      if (idx < n) fail_now("drain_timeout");
      else if (n > 0) begin
        if (!gaps) begin
          check_int("in_rd_cycles", 32'(rdc), 32'(n));
          check_int("last_in_xfer_edge", 32'(last), 32'(t + n));
        end
        @(negedge clk);
        check_int("in_rd_low_after_drain", 32'(in_rd), 32'd0);
        @(posedge clk); #1;
      end
    end
  endtask

  // READOUT; mode 0 = always ready, 1 = fixed ready pattern, 2 = random ready.
  task automatic readout(input int base, input int len, input bit relu, input int mode);
    int t, n, cnt, b, i, first, last;
    cnt = 0; b = 0; i = 0; first = -1; last = -1;
    issue(2, base, len, relu, t);
    n = eff_len(2, len);
    while (cnt < n && b < 8 * n + 50) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = rdy_pat[i % 7];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (out_valid && out_ready) begin
        cnt++;
        if (first < 0) first = cyc + 1;
        last = cyc + 1;
        if (cnt == n) exp_done.push_back(cyc + 2);
      end
      @(posedge clk); #1;
      b++; i++;
    end
    out_ready = 1'b1;
    if (cnt < n) fail_now("readout_timeout");
    else if (n > 0 && mode == 0) begin
      check_int("first_out_cycle", 32'(first), 32'(t + 2));
      check_int("last_out_cycle", 32'(last), 32'(t + n + 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, op, base, len;
    logic [W-1:0] saved;

    // Reset behaviour.
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check_int("rst_cmd_ready_during", 32'(cmd_ready), 32'd0);
    check_int("rst_in_rd_during", 32'(in_rd), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_int("rst_cmd_ready_after", 32'(cmd_ready), 32'd1);
    check_int("rst_out_valid", 32'(out_valid), 32'd0);
    check_row("rst_out_data", out_data, '0);
    check_int("rst_done", 32'(done), 32'd0);
    check_int("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Oversized length clamps to depth; fills every row.
    src_rows.delete();
    for (int i = 0; i < DEPTH; i++) src_rows.push_back(rand_row());
    drain(0, 0, 4000, 1'b0, 0);
    readout(0, 4000, 1'b0, 2);

    // Basic WRITE then READOUT.
    src_rows = '{rep(1), rep(2), rep(3)};
    drain(0, 5, 3, 1'b0, 0);
    readout(5, 3, 1'b0, 0);

    // ACCUM over stored rows.
    src_rows = '{rep(10), rep(20), rep(30)};
    drain(1, 5, 3, 1'b0, 0);
    readout(5, 3, 1'b0, 0);

    // Saturation at both ends of the lane range.
    src_rows = '{alt(32760, -32760)};
    drain(0, 40, 1, 1'b0, 0);
    src_rows = '{alt(100, -100)};
    drain(1, 40, 1, 1'b0, 0);
    readout(40, 1, 1'b0, 0);

    // Address wrap.
    src_rows.delete();
    for (int i = 0; i < 4; i++) src_rows.push_back(rand_row());
    drain(0, 2046, 4, 1'b0, 0);
    readout(2046, 4, 1'b0, 0);

    // Back-pressure and input bubbles.
    readout(2046, 4, 1'b0, 1);
    src_rows.delete();
    for (int i = 0; i < 6; i++) src_rows.push_back(rand_row());
    drain(1, 200, 6, 1'b1, 0);
    readout(200, 6, 1'b0, 1);

    // ReLU on and off.
    src_rows = '{alt(-5, 7)};
    drain(0, 60, 1, 1'b0, 0);
    readout(60, 1, 1'b1, 0);
    readout(60, 1, 1'b0, 0);

    // Reset in the middle of an ACCUM: the row staged for write is dropped.
    src_rows.delete();
    for (int i = 0; i < 4; i++) src_rows.push_back(rand_row());
    saved = ref_mem[101];
    drain(1, 100, 4, 1'b0, 2);
    reset = 1'b1;
    ref_mem[101] = saved;
    @(negedge clk);
    check_int("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_int("midrst_in_rd", 32'(in_rd), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_int("midrst_busy", 32'(busy), 32'd0);
    check_int("midrst_done", 32'(done), 32'd0);
    check_int("midrst_out_valid", 32'(out_valid), 32'd0);
    check_int("midrst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // Zero-length command.
    issue(0, 7, 0, 1'b0, t);
    @(negedge clk);
    check_int("len0_busy_flush", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_int("len0_idle_after", 32'(busy), 32'd0);
    check_int("len0_ready_after", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    readout(100, 4, 1'b0, 0);

    // Randomised command mix.
    for (int it = 0; it < 30; it++) begin
      op   = $urandom_range(0, 3);
      base = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(0, 10);
      if (op == 2) begin
        readout(base, len, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end else if (op == 3) begin
        issue(3, base, len, 1'b0, t);
      end else begin
        src_rows.delete();
        for (int i = 0; i < len; i++) src_rows.push_back(rand_row());
        drain(op, base, len, 1'($urandom_range(0, 1)), 0);
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check_int("rows_left", 32'(exp_rows.size()), 32'd0);
    check_int("dones_left", 32'(exp_done.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_accum_buffer.md
# psum_accum_buffer

Parametrised partial-sum buffer between the corelet OFIFO output and the SFP input, replacing the fixed 128-bit-wide, 2048-deep psum SRAM. Commands are issued over a valid/ready handshake:
- WRITE drains OFIFO rows into a contiguous address range.
- ACCUM drains OFIFO rows and adds them into the stored rows (read-modify-write, saturating per lane). This allows partial sums from successive kernel tiles to be combined without a host round-trip.
- READOUT streams stored rows to the SFP under back-pressure, with optional ReLU.

## Interface
Parameters:
- psum_bw, 16, bits per lane (signed)
- col, 8, lanes per row
- depth, 2048, rows of storage
- addr_bw, 11, address width; requires 2**addr_bw == depth

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset; one clock; sampled on rising edge of clk
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block idle, command accepted when cmd_valid&cmd_ready
- cmd_op  input  2  0=WRITE, 1=ACCUM, 2=READOUT, 3=reserved (accepted, treated as len 0)
- cmd_base  input  addr_bw  first row address
- cmd_len  input  addr_bw+1  row count
- cmd_relu  input  1  READOUT only: clamp negative lanes to 0
- in_valid  input  1  OFIFO has a row (ofifo valid)
- in_data  input  psum_bw*col  OFIFO row; lane k at bits [psum_bw*(k+1)-1 : psum_bw*k]
- in_rd  output  1  pop; a row transfers when in_valid&in_rd
- out_valid  output  1  out_data holds a row
- out_data  output  psum_bw*col  row to SFP
- out_ready  input  1  SFP consumes; transfer when out_valid&out_ready
- done  output  1  one-cycle pulse at command completion
- busy  output  1  state != IDLE

## Operation
- FSM states: IDLE, DRAIN (WRITE/ACCUM), READ, FLUSH.
- Command capture:
  - IDLE with cmd_valid: latch op, base, len, relu into registers.
  - addr <= cmd_base; remaining <= min(cmd_len, depth).
  - Next state: DRAIN or READ; FLUSH if len==0 or op==3.
- Address arithmetic: addr increments by 1 per transferred row and wraps modulo depth (depth-1 -> 0).
- DRAIN:
  - in_rd = (remaining != 0); combinational from state and counter, never from in_valid.
  - Each transfer: remaining -= 1; addr += 1.
  - WRITE: mem[addr] <= in_data at the transfer edge.
  - ACCUM, stage 0 (transfer cycle): read mem[addr] into acc_old; register in_data and addr into stage-1 regs.
  - ACCUM, stage 1 (next cycle): per lane, signed saturating add of acc_old and staged data, clamped to [-2**(psum_bw-1), 2**(psum_bw-1)-1]; write the result to the staged addr.
  - ACCUM sustains 1 row/cycle. Read address a+1 never equals write address a because len ≤ depth, so no forwarding is needed.
  - remaining reaches 0 -> FLUSH.
- READ:
  - Output register loads mem[addr] (ReLU applied if relu) at an edge where (!out_valid || out_ready) and remaining != 0; then remaining -= 1, addr += 1.
  - remaining==0 and the last row has transferred (out_valid&out_ready, or !out_valid) -> FLUSH.
- FLUSH: waits one cycle for any stage-1 ACCUM write to commit, pulses done, then goes to IDLE.
- Memory contents are not cleared by reset.

## Timing
- Reset values: cmd_ready=0 during reset, 1 in the first cycle after; in_rd=0, out_valid=0, out_data=0, done=0, busy=0. FSM goes to IDLE, counters and pipeline valids are cleared.
- Reset mid-operation: abandons the command immediately. Any pending ACCUM stage-1 write is dropped. No done pulse.
- cmd_ready = (state==IDLE) && !reset. A command is accepted at edge T; busy=1 from T+1.
- WRITE/ACCUM: the first in_rd is high in cycle T+1. For an uninterrupted in_valid stream of N rows:
  - WRITE: done pulses in cycle T+N+2.
  - ACCUM: last write commits at edge T+N+1; done pulses in cycle T+N+2.
- READOUT, out_ready held high: first out_valid in cycle T+2, one row per cycle, done in cycle T+N+2.
- out_data is held stable while out_valid&!out_ready.
- len 0: done pulses in cycle T+1 (FLUSH), IDLE in cycle T+2.
- cmd_len > depth is clamped to depth.
- A new command may be presented while done is high; it is accepted only when cmd_ready is high (cycle after done).

## Test plan
- WRITE base=5, len=3, rows {1,2,3} replicated in all lanes, in_valid always high -> in_rd high for exactly 3 cycles, done at T+5; then READOUT base=5 len=3 returns 1,2,3 in order.
- ACCUM base=5 len=3 with rows {10,20,30} over the stored {1,2,3} -> READOUT gives 11,22,33. Repeat with stored 32760 + 100 -> lane saturates to 32767; -32760 + -100 -> -32768.
- Wrap: WRITE base=2046 len=4 -> rows land at 2046, 2047, 0, 1; READOUT base=2046 len=4 matches.
- Back-pressure and bubbles: READOUT len=4 with out_ready toggling 1,0,0,1,1,0,1; in_valid gaps during ACCUM -> no duplicated or lost rows, out_data stable while stalled, final memory correct.
- ReLU: READOUT relu=1 over lanes {-5, 7} -> {0, 7}; relu=0 -> {-5, 7}.
- Reset asserted mid-ACCUM (after 2 of 4 rows) -> all outputs are at reset values the next cycle and no done pulse; rows already committed stay; a subsequent command is accepted and cmd_len=0 gives done at T+1.
